// File: rtl/ssd_scanner.sv
// rtl/ssd_scanner.sv - 4-digit multiplexed seven-segment scanner
// Per-slot blanking against ghosting, registered outputs, and a frame strobe.
`timescale 1ns/100ps
module ssd_scanner #(
   parameter int DIV   = 1024,
   parameter int BLANK = 8
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       digit0_en_i,
   input  logic       digit1_en_i,
   input  logic       digit2_en_i,
   input  logic       digit3_en_i,
   input  logic [3:0] digit0_i,
   input  logic [3:0] digit1_i,
   input  logic [3:0] digit2_i,
   input  logic [3:0] digit3_i,
   output logic [3:0] anode_o,
   output logic [6:0] segments_o,
   output logic       frame_o
);

   localparam int CW = $clog2(DIV);
   localparam logic [CW-1:0] CNT_MAX   = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;
   logic [3:0]    cap_val_q, cap_val_d;
   logic          cap_en_q, cap_en_d;
   logic [3:0]    anode_q, anode_d;
   logic [6:0]    seg_q, seg_d;
   logic          frame_q, frame_d;
   logic [1:0]    nxt_idx;
   logic [3:0]    sel_val;
   logic          sel_en;
   logic          slot_end;

   // Active-low {g,f,e,d,c,b,a}
   function automatic logic [6:0] decode(input logic [3:0] v);
      case (v)
         4'h0:    decode = 7'b1000000;
         4'h1:    decode = 7'b1111001;
         4'h2:    decode = 7'b0100100;
         4'h3:    decode = 7'b0110000;
         4'h4:    decode = 7'b0011001;
         4'h5:    decode = 7'b0010010;
         4'h6:    decode = 7'b0000010;
         4'h7:    decode = 7'b1111000;
         4'h8:    decode = 7'b0000000;
         4'h9:    decode = 7'b0010000;
         4'hA:    decode = 7'b0001000;
         4'hB:    decode = 7'b0000011;
         4'hC:    decode = 7'b1000110;
         4'hD:    decode = 7'b0100001;
         4'hE:    decode = 7'b0000110;
         default: decode = 7'b0001110;
      endcase
   endfunction

   always_comb begin
      nxt_idx  = idx_q + 2'd1;
      slot_end = (cnt_q == CNT_MAX);
      case (nxt_idx)
         2'd0:    begin sel_val = digit0_i; sel_en = digit0_en_i; end
         2'd1:    begin sel_val = digit1_i; sel_en = digit1_en_i; end
         2'd2:    begin sel_val = digit2_i; sel_en = digit2_en_i; end
         default: begin sel_val = digit3_i; sel_en = digit3_en_i; end
      endcase

      cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
      idx_d     = slot_end ? nxt_idx : idx_q;
      cap_val_d = slot_end ? sel_val : cap_val_q;
      cap_en_d  = slot_end ? sel_en  : cap_en_q;

      // Outputs are computed from the current slot state only; inputs never reach them directly.
      anode_d = 4'b1111;
      seg_d   = 7'b1111111;
      if (cap_en_q && (cnt_q >= CNT_BLANK)) begin
         anode_d = ~(4'b0001 << idx_q);
         seg_d   = decode(cap_val_q);
      end
      frame_d = slot_end && (idx_q == 2'd3);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q     <= '0;
         idx_q     <= 2'd0;
         cap_val_q <= 4'd0;
         cap_en_q  <= 1'b0;
         anode_q   <= 4'b1111;
         seg_q     <= 7'b1111111;
         frame_q   <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         cap_val_q <= cap_val_d;
         cap_en_q  <= cap_en_d;
         anode_q   <= anode_d;
         seg_q     <= seg_d;
         frame_q   <= frame_d;
      end
   end

   assign anode_o    = anode_q;
   assign segments_o = seg_q;
   assign frame_o    = frame_q;

endmodule

// File: tb/tb_ssd_scanner.sv
// tb/tb_ssd_scanner.sv - self-checking bench for ssd_scanner
// Reference model derives outputs from the cycle count since reset and per-slot input snapshots.
`timescale 1ns/100ps
module tb_ssd_scanner;
   localparam int DIV   = 8;
   localparam int BLANK = 2;

   logic       clk = 1'b0;
   logic       rst_ni;
   logic       d_en  [4];
   logic [3:0] d_val [4];
   logic [3:0] anode_o;
   logic [6:0] segments_o;
   logic       frame_o;

   int checks = 0;
   int failures = 0;
   int k = 0;
   int snap_en  [1024];
   int snap_val [1024];
   logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   ssd_scanner #(.DIV(DIV), .BLANK(BLANK)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .digit0_en_i(d_en[0]), .digit1_en_i(d_en[1]), .digit2_en_i(d_en[2]), .digit3_en_i(d_en[3]),
      .digit0_i(d_val[0]), .digit1_i(d_val[1]), .digit2_i(d_val[2]), .digit3_i(d_val[3]),
      .anode_o(anode_o), .segments_o(segments_o), .frame_o(frame_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h (k=%0d)", tag, obs, exp, k);
      end
   endtask

   // One cycle: latch what the upcoming capture edge will see, then check the post-edge outputs.
   task automatic tick();
      int s, p;
      logic [3:0] ea;
      logic [6:0] es;
      if ((k + 1) % DIV == 0) begin
         s = (k + 1) / DIV;
         snap_en[s % 1024]  = int'(d_en[s % 4]);
         snap_val[s % 1024] = int'(d_val[s % 4]);
      end
      @(negedge clk);
      k++;
      s  = (k - 1) / DIV;
      p  = (k - 1) % DIV;
      ea = 4'hF;
      es = 7'h7F;
      if (s > 0 && p >= BLANK && snap_en[s % 1024] != 0) begin
         ea = ~(4'b0001 << (s % 4));
         es = seg_tbl[snap_val[s % 1024]];
      end
      chk("anode", anode_o, ea);
      chk("segments", segments_o, es);
      chk("frame", frame_o, (k % (4 * DIV) == 0) ? 1'b1 : 1'b0);
   endtask

   task automatic wait_anode(input logic [3:0] target, input string tag);
      int n = 0;
      while (anode_o !== target && n < 80) begin
         tick();
         n++;
      end
      chk(tag, anode_o, target);
   endtask

   // Anti-ghosting and one-hot monitor, active in every scenario
   logic [3:0] last_lit = 4'hF;
   int gap = 0;
   always @(negedge clk) begin
      if (rst_ni) begin
         checks++;
         assert ($countones(~anode_o) <= 1) else begin
            failures++;
            $error("FAIL onehot observed=%b expected=at_most_one_low", anode_o);
         end
         if (anode_o != 4'hF) begin
            if (last_lit != 4'hF && anode_o != last_lit) begin
               checks++;
               assert (gap >= BLANK) else begin
                  failures++;
                  $error("FAIL ghost_gap observed=%0d expected>=%0d", gap, BLANK);
               end
            end
            last_lit = anode_o;
            gap = 0;
         end else begin
            gap++;
         end
      end
   end

   initial begin
      int nframes;
      for (int i = 0; i < 4; i++) begin
         d_en[i]  = 1'b1;
         d_val[i] = 4'(i);
      end
      rst_ni = 1'b1;
      #1 rst_ni = 1'b0;
      #6;
      chk("rst_anode", anode_o, 4'hF);
      chk("rst_segments", segments_o, 7'h7F);
      chk("rst_frame", frame_o, 1'b0);
      #5 rst_ni = 1'b1;
      k = 0;

      // All digits lit, digitN = N
      repeat (4 * 32 + 8) tick();

      // digit2 disabled
      d_en[2] = 1'b0;
      repeat (80) tick();
      d_en[2] = 1'b1;

      // Mid-window change of digit0 must not disturb the current slot
      d_val[0] = 4'h8;
      repeat (40) tick();
      wait_anode(4'b1110, "find_digit0_window");
      d_val[0] = 4'hF;
      tick();
      chk("digit0_hold", segments_o, 7'h00);
      repeat (8) tick();
      wait_anode(4'b1110, "find_next_digit0");
      chk("digit0_new", segments_o, 7'h0E);

      // Frame strobe cadence
      nframes = 0;
      repeat (64) begin
         tick();
         if (frame_o === 1'b1) nframes++;
      end
      chk("frame_count_64", nframes, 2);

      // Short asynchronous reset inside a lit window
      wait_anode(4'b1101, "find_lit_for_reset");
      #2 rst_ni = 1'b0;
      #0.5;
      chk("async_anode", anode_o, 4'hF);
      chk("async_segments", segments_o, 7'h7F);
      chk("async_frame", frame_o, 1'b0);
      #0.5 rst_ni = 1'b1;
      k = 0;
      repeat (48) tick();

      // Every hex value on digit3
      for (int v = 0; v < 16; v++) begin
         d_val[3] = 4'(v);
         repeat (32) tick();
      end

      // Random input churn
      repeat (1500) begin
         if ($urandom_range(7) == 0) begin
            int di;
            di = $urandom_range(3);
            d_val[di] = 4'($urandom_range(15));
            d_en[di]  = ($urandom_range(3) != 0);
         end
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ssd_scanner.md
SSD_SCANNER -- requirements
Module: ssd_scanner

Interface
REQ-001 The block SHALL have parameter DIV, default 1024: clock cycles per digit slot; legal range 4..65536.
REQ-002 The block SHALL have parameter BLANK, default 8: leading blanked cycles per slot; legal range 1..DIV-2.
REQ-003 The block SHALL have port clk_i, input, 1: single clock for the whole block.
REQ-004 The block SHALL have port rst_ni, input, 1: asynchronous, active-low reset.
REQ-005 The block SHALL have ports digit0_en_i..digit3_en_i, input, 1 each: digit N lit when 1, blank when 0.
REQ-006 The block SHALL have ports digit0_i..digit3_i, input, 4 each: hex value of digit N (digit0 rightmost).
REQ-007 The block SHALL have port anode_o, input-to-panel output, 4: active-low digit select, bit N = digit N.
REQ-008 The block SHALL have port segments_o, output, 7: active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-009 The block SHALL have port frame_o, output, 1: one-cycle pulse at the start of each full 4-digit scan.

Function
REQ-010 The block SHALL keep a slot counter cnt: 0..DIV-1, +1 per cycle, wrap DIV-1 -> 0.
REQ-011 The block SHALL keep a digit index idx: 0..3, advance (3 -> 0 wrap) on the cycle cnt==DIV-1.
REQ-012 On the cycle cnt==DIV-1, the block SHALL capture digit[idx+1 mod 4] and digit_en[idx+1 mod 4] into cap_val/cap_en.
REQ-013 Inputs SHALL be sampled only at REQ-012; changes mid-slot SHALL NOT affect the current slot.
REQ-014 anode_o, segments_o and frame_o SHALL be registered, with no combinational path from inputs to outputs.
REQ-015 Each cycle with cnt>=BLANK and cap_en==1, the registered outputs SHALL load anode_o=~(1<<idx) and segments_o=decode(cap_val).
REQ-016 All other cycles (cnt<BLANK, or cap_en==0), outputs SHALL load anode_o=4'b1111 and segments_o=7'b1111111.
REQ-017 As a consequence of REQ-015/016, each lit window SHALL be DIV-BLANK cycles long, lagging the cnt window by 1 cycle.
REQ-018 At most one anode_o bit SHALL be low in any cycle.
REQ-019 anode_o SHALL return to 4'b1111 for at least BLANK cycles between any two distinct lit digits (anti-ghosting).
REQ-020 decode SHALL be standard hex, 0-9 and A,b,C,d,E,F, e.g. 0->1000000, 1->1111001, 8->0000000, A->0001000, F->0001110.
REQ-021 frame_o SHALL be 1 for exactly the one cycle after idx wraps 3->0, and 0 otherwise.
REQ-022 Counter widths SHALL be $clog2(DIV) bits, with no overflow beyond DIV-1.

Reset
REQ-023 While rst_ni==0, asynchronously: cnt=0, idx=0, cap_val=0, cap_en=0, anode_o=4'b1111, segments_o=7'b1111111, frame_o=0.
REQ-024 After release, slot 0 SHALL stay fully blank (cap_en=0), and first capture (digit1) SHALL occur at cnt==DIV-1.
REQ-025 Reset asserted mid-slot SHALL blank outputs immediately, without waiting for a clock edge.
REQ-026 After a mid-slot reset is released, the sequence SHALL restart per REQ-024 with no partial-slot artefacts.

Verification (DIV=8, BLANK=2)
REQ-027 Bench SHALL cover: all en=1, digits 3,2,1,0 -> per slot 2 cycles 1111/1111111, then 6 cycles anode 1110 seg 1000000 (digit0), then 1101 seg 1111001, 1011, 0111, then repeat.
REQ-028 Bench SHALL cover: digit2_en=0, others 1 -> digit2 slot all 8 cycles anode 1111; other slots per REQ-027.
REQ-029 Bench SHALL cover: digit0_i changes 8->F mid digit0 lit window -> segments stay 0000000 until the slot ends; 0001110 appears next frame.
REQ-030 Bench SHALL cover: free run 64 cycles -> frame_o high exactly every 32 cycles, one cycle wide.
REQ-031 Bench SHALL cover: rst_ni low for 1 ns between clock edges during a lit window -> outputs 1111/1111111 within that interval.
REQ-032 Bench SHALL cover: all 16 hex values on digit3 -> segments match the REQ-020 table, with anode 0111.
REQ-033 Bench SHALL continuously assert REQ-018 and REQ-019 in all scenarios.
